// File: rtl/motor_drive_shaper.sv
// Duty/direction shaper for one H-bridge channel.
// Slews the PWM duty by at most STEP per PWM period. A direction reversal
// ramps the duty to zero, keeps the bridge off for DEAD_TICKS periods, passes
// through STOP, and only then drives the new direction. Every register moves
// only on period_tick, so all timing is counted in PWM periods.
module motor_drive_shaper #(
  parameter int unsigned SIZE       = 12,
  parameter int unsigned MAX_DUTY   = 4000,
  parameter int unsigned STEP       = 100,
  parameter int unsigned DEAD_TICKS = 3     // legal range 1..255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            period_tick,
  input  logic [SIZE-1:0] duty_cmd,
  input  logic            dir_cmd,
  output logic [SIZE-1:0] duty_out,
  output logic [1:0]      hb_in,
  output logic            busy,
  output logic [1:0]      state
);

  // State codes are visible on the debug port, so the encoding is fixed.
  typedef enum logic [1:0] {
    StStop  = 2'd0,
    StRun   = 2'd1,
    StDecel = 2'd2,
    StDead  = 2'd3
  } state_e;

  localparam logic [SIZE-1:0] MaxDutyW = SIZE'(MAX_DUTY);
  localparam logic [SIZE-1:0] StepW    = SIZE'(STEP);
  localparam logic [7:0]      DeadInit = 8'(DEAD_TICKS);

  // Bridge drive codes; 2'b11 would short the bridge and is never produced.
  localparam logic [1:0] HbFwd = 2'b10;
  localparam logic [1:0] HbRev = 2'b01;
  localparam logic [1:0] HbOff = 2'b00;

  state_e          state_q, state_d;
  logic [SIZE-1:0] duty_q, duty_d;
  logic            dir_q, dir_d;
  logic [7:0]      dead_q, dead_d;

  logic [SIZE-1:0] target;
  logic [SIZE-1:0] duty_to_target;
  logic [SIZE-1:0] duty_to_zero;

  // Move cur toward goal by at most StepW, landing exactly on goal when close.
  // goal never exceeds MaxDutyW, so cur + StepW cannot pass it or overflow,
  // and cur - StepW is only taken when cur is more than StepW above goal.
  function automatic logic [SIZE-1:0] step_toward(input logic [SIZE-1:0] cur,
                                                  input logic [SIZE-1:0] goal);
    logic [SIZE-1:0] result;
    if (goal >= cur) begin
      if ((goal - cur) <= StepW) begin
        result = goal;
      end else begin
        result = cur + StepW;
      end
    end else begin
      if ((cur - goal) <= StepW) begin
        result = goal;
      end else begin
        result = cur - StepW;
      end
    end
    return result;
  endfunction

  // Saturated target and the two candidate next duties.
  always_comb begin
    target         = (duty_cmd > MaxDutyW) ? MaxDutyW : duty_cmd;
    duty_to_target = step_toward(duty_q, target);
    duty_to_zero   = step_toward(duty_q, '0);
  end

  // State register: everything advances only on a PWM period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StStop;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      dead_q  <= '0;
    end else if (period_tick) begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
    end
  end

  // Next-state logic, evaluated for the coming period_tick.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;

    unique case (state_q)
      StStop: begin
        duty_d = '0;
        // Latch the direction now; duty starts stepping on the following tick.
        if (target != '0) begin
          dir_d   = dir_cmd;
          state_d = StRun;
        end
      end

      StRun: begin
        if (dir_cmd == dir_q) begin
          duty_d = duty_to_target;
        end else begin
          // Reversal wins over any simultaneous target change.
          duty_d = duty_to_zero;
          if (duty_to_zero == '0) begin
            state_d = StDead;
            dead_d  = DeadInit;
          end else begin
            state_d = StDecel;
          end
        end
      end

      StDecel: begin
        if (dir_cmd == dir_q) begin
          // Reversal withdrawn before the duty reached zero.
          duty_d  = duty_to_target;
          state_d = StRun;
        end else begin
          duty_d = duty_to_zero;
          if (duty_to_zero == '0) begin
            state_d = StDead;
            dead_d  = DeadInit;
          end
        end
      end

      StDead: begin
        // Commands are ignored; only the dead-time counter moves.
        duty_d = '0;
        dead_d = dead_q - 8'd1;
        if (dead_q == 8'd1) begin
          state_d = StStop;
        end
      end

      default: begin
        state_d = StStop;
        duty_d  = '0;
      end
    endcase
  end

  // Outputs: the bridge is driven only in RUN and DECEL, off otherwise.
  always_comb begin
    hb_in    = HbOff;
    busy     = 1'b0;
    duty_out = duty_q;
    state    = state_q;

    unique case (state_q)
      StRun:   hb_in = dir_q ? HbRev : HbFwd;
      StDecel: begin
        hb_in = dir_q ? HbRev : HbFwd;
        busy  = 1'b1;
      end
      StDead:  busy = 1'b1;
      default: hb_in = HbOff;
    endcase
  end

  // Bridge safety properties: no shoot-through code, no direct reversal.
  a_no_shoot: assert property (@(posedge clk) disable iff (!rst_n) hb_in != 2'b11);
  a_fwd_rev: assert property (@(posedge clk) disable iff (!rst_n)
                              (hb_in == HbFwd) |=> (hb_in != HbRev));
  a_rev_fwd: assert property (@(posedge clk) disable iff (!rst_n)
                              (hb_in == HbRev) |=> (hb_in != HbFwd));

endmodule

// File: tb/tb_motor_drive_shaper.sv
// Directed, table-driven bench for motor_drive_shaper (STEP=100,
// DEAD_TICKS=3, MAX_DUTY=4000). Each table row is one period_tick.
module tb_motor_drive_shaper;

  logic        clk;
  logic        rst_n;
  logic        period_tick;
  logic [11:0] duty_cmd;
  logic        dir_cmd;
  logic [11:0] duty_out;
  logic [1:0]  hb_in;
  logic        busy;
  logic [1:0]  state;

  int num_checks = 0;
  int num_fails  = 0;

  typedef struct {
    logic [11:0] duty;
    logic        dir;
    logic [11:0] exp_duty;
    logic [1:0]  exp_hb;
    logic [1:0]  exp_state;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];

  motor_drive_shaper #(
    .SIZE       (12),
    .MAX_DUTY   (4000),
    .STEP       (100),
    .DEAD_TICKS (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_tick (period_tick),
    .duty_cmd    (duty_cmd),
    .dir_cmd     (dir_cmd),
    .duty_out    (duty_out),
    .hb_in       (hb_in),
    .busy        (busy),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bridge safety monitor, sampled away from the active edge.
  logic [1:0] prev_hb = 2'b00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hb = 2'b00;
    end else begin
      num_checks++;
      if (hb_in == 2'b11 || (prev_hb == 2'b10 && hb_in == 2'b01) ||
          (prev_hb == 2'b01 && hb_in == 2'b10)) begin
        num_fails++;
        $display("FAIL hb_safety at %0t: hb_in=%b previous=%b", $time, hb_in, prev_hb);
      end
      prev_hb = hb_in;
    end
  end

  task automatic check(input string name, input logic [11:0] e_duty, input logic [1:0] e_hb,
                       input logic [1:0] e_state, input logic e_busy);
    num_checks++;
    if (duty_out !== e_duty || hb_in !== e_hb || state !== e_state || busy !== e_busy) begin
      num_fails++;
      $display("FAIL %s: got duty=%0d hb=%b state=%0d busy=%b, want duty=%0d hb=%b state=%0d busy=%b",
               name, duty_out, hb_in, state, busy, e_duty, e_hb, e_state, e_busy);
    end
  endtask

  task automatic do_tick(input logic [11:0] d, input logic dir);
    @(negedge clk);
    duty_cmd    = d;
    dir_cmd     = dir;
    period_tick = 1'b1;
    @(posedge clk);
    #1;
    period_tick = 1'b0;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      do_tick(tbl[i].duty, tbl[i].dir);
      check($sformatf("vec%0d", i), tbl[i].exp_duty, tbl[i].exp_hb, tbl[i].exp_state,
            tbl[i].exp_busy);
    end
  endtask

  initial begin
    // duty, dir, exp_duty, exp_hb, exp_state, exp_busy
    // 0..3: start forward toward 450
    tbl.push_back('{12'd450, 1'b0, 12'd0,   2'b10, 2'd1, 1'b0});
    tbl.push_back('{12'd450, 1'b0, 12'd100, 2'b10, 2'd1, 1'b0});
    tbl.push_back('{12'd450, 1'b0, 12'd200, 2'b10, 2'd1, 1'b0});
    tbl.push_back('{12'd450, 1'b0, 12'd300, 2'b10, 2'd1, 1'b0});
    // 4..6: finish the ramp and hold
    tbl.push_back('{12'd450, 1'b0, 12'd400, 2'b10, 2'd1, 1'b0});
    tbl.push_back('{12'd450, 1'b0, 12'd450, 2'b10, 2'd1, 1'b0});
    tbl.push_back('{12'd450, 1'b0, 12'd450, 2'b10, 2'd1, 1'b0});
    // 7..: ramp to 250 forward, reverse through DECEL/DEAD/STOP
    tbl.push_back('{12'd250, 1'b0, 12'd100, 2'b10, 2'd1, 1'b0});
    tbl.push_back('{12'd250, 1'b0, 12'd200, 2'b10, 2'd1, 1'b0});
    tbl.push_back('{12'd250, 1'b0, 12'd250, 2'b10, 2'd1, 1'b0});
    tbl.push_back('{12'd250, 1'b1, 12'd150, 2'b10, 2'd2, 1'b1});
    tbl.push_back('{12'd250, 1'b1, 12'd50,  2'b10, 2'd2, 1'b1});
    tbl.push_back('{12'd250, 1'b1, 12'd0,   2'b00, 2'd3, 1'b1});
    // dead time: commands toggle but are ignored, three ticks then STOP
    tbl.push_back('{12'd4000, 1'b0, 12'd0,  2'b00, 2'd3, 1'b1});
    tbl.push_back('{12'd100,  1'b1, 12'd0,  2'b00, 2'd3, 1'b1});
    tbl.push_back('{12'd0,    1'b0, 12'd0,  2'b00, 2'd0, 1'b0});
    tbl.push_back('{12'd250, 1'b1, 12'd0,   2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd250, 1'b1, 12'd100, 2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd250, 1'b1, 12'd200, 2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd250, 1'b1, 12'd250, 2'b01, 2'd1, 1'b0});
    // reversal plus new target together: DECEL, then abort back to RUN
    tbl.push_back('{12'd450, 1'b0, 12'd150, 2'b01, 2'd2, 1'b1});
    tbl.push_back('{12'd450, 1'b1, 12'd250, 2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd450, 1'b1, 12'd350, 2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd450, 1'b1, 12'd450, 2'b01, 2'd1, 1'b0});
    // ramp to zero, then reverse from duty 0 straight into DEAD
    tbl.push_back('{12'd0, 1'b1, 12'd350, 2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd0, 1'b1, 12'd250, 2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd0, 1'b1, 12'd150, 2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd0, 1'b1, 12'd50,  2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd0, 1'b1, 12'd0,   2'b01, 2'd1, 1'b0});
    tbl.push_back('{12'd0, 1'b0, 12'd0,   2'b00, 2'd3, 1'b1});
    tbl.push_back('{12'd0, 1'b1, 12'd0,   2'b00, 2'd3, 1'b1});
    tbl.push_back('{12'd0, 1'b1, 12'd0,   2'b00, 2'd3, 1'b1});
    tbl.push_back('{12'd0, 1'b1, 12'd0,   2'b00, 2'd0, 1'b0});
    // STOP with zero target stays put; then restart forward
    tbl.push_back('{12'd0,   1'b0, 12'd0,   2'b00, 2'd0, 1'b0});
    tbl.push_back('{12'd300, 1'b0, 12'd0,   2'b10, 2'd1, 1'b0});
    tbl.push_back('{12'd300, 1'b0, 12'd100, 2'b10, 2'd1, 1'b0});

    rst_n       = 1'b0;
    period_tick = 1'b0;
    duty_cmd    = '0;
    dir_cmd     = 1'b0;
    #2;
    check("reset_initial", 12'd0, 2'b00, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_range(0, 3);

    // Commands churn with no period_tick: nothing may move.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (duty_out !== 12'd300 || hb_in !== 2'b10 || state !== 2'd1 || busy !== 1'b0) begin
        num_fails++;
        $display("FAIL freeze cycle %0d: duty=%0d hb=%b state=%0d busy=%b, want 300/10/1/0",
                 c, duty_out, hb_in, state, busy);
      end
      num_checks++;
      duty_cmd = 12'($urandom);
      dir_cmd  = 1'($urandom);
    end

    run_range(4, 6);

    // Ramp up from 450 toward 4095, clamped at 4000.
    for (int k = 1; k <= 38; k++) begin
      int e;
      e = 450 + 100 * k;
      if (e > 4000) e = 4000;
      do_tick(12'd4095, 1'b0);
      check($sformatf("clamp_up%0d", k), 12'(e), 2'b10, 2'd1, 1'b0);
    end
    // Ramp down to zero, staying in RUN.
    for (int k = 1; k <= 41; k++) begin
      int e;
      e = 4000 - 100 * k;
      if (e < 0) e = 0;
      do_tick(12'd0, 1'b0);
      check($sformatf("ramp_down%0d", k), 12'(e), 2'b10, 2'd1, 1'b0);
    end

    run_range(7, tbl.size() - 1);

    // Reset mid-operation, inside a clock phase with no edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_midop", 12'd0, 2'b00, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_tick(12'd300, 1'b0);
    check("restart_stop", 12'd0, 2'b10, 2'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
